// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, EX-stage forwarding and stall accounting for a 5-stage in-order pipeline.
// Pipeline occupancy is tracked in shadow EX/MEM/WB registers that mirror the datapath.
module pipe_hazard_ctrl #(
  parameter int unsigned RW     = 5,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned BR_ID  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             flush_fd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic          ex_v_q, ex_wr_q, ex_ld_q, ex_use1_q, ex_use2_q;
  logic [RW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic          mem_v_q, mem_wr_q, mem_ld_q;
  logic [RW-1:0] mem_rd_q;
  logic          wb_v_q, wb_wr_q;
  logic [RW-1:0] wb_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic adv, hazard, match_ex, match_mem;

  // A stage produces a value the ID instruction reads; x0 is never a producer.
  function automatic logic src_match(input logic v, input logic wr, input logic [RW-1:0] rd,
                                     input logic use1, input logic [RW-1:0] rs1,
                                     input logic use2, input logic [RW-1:0] rs2);
    return v & wr & (rd != '0) & ((use1 & (rs1 == rd)) | (use2 & (rs2 == rd)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [RW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_v_q & use_src & (rs != '0)) begin
      if (mem_v_q & mem_wr_q & (mem_rd_q == rs)) begin
        sel = 2'b10;
      end else if (wb_v_q & wb_wr_q & (wb_rd_q == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  assign adv = ~mem_busy;

  always_comb begin
    match_ex  = src_match(ex_v_q, ex_wr_q, ex_rd_q, id_use1, id_rs1, id_use2, id_rs2);
    match_mem = src_match(mem_v_q, mem_wr_q, mem_rd_q, id_use1, id_rs1, id_use2, id_rs2);
    hazard    = 1'b0;
    if (match_ex & ex_ld_q) begin
      hazard = 1'b1;
    end
    if ((FWD_EN == 0) & (match_ex | match_mem)) begin
      hazard = 1'b1;
    end
    if ((BR_ID == 1) & id_is_branch & (match_ex | (match_mem & mem_ld_q))) begin
      hazard = 1'b1;
    end
    hazard = hazard & id_valid;
  end

  always_comb begin
    freeze    = mem_busy;
    stall_fd  = mem_busy | hazard;
    bubble_ex = hazard & ~mem_busy;
    flush_fd  = id_valid & id_is_branch & br_taken & ~hazard & ~mem_busy;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a = fwd_sel(ex_use1_q, ex_rs1_q);
      fwd_b = fwd_sel(ex_use2_q, ex_rs2_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q    <= 1'b0;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
      ex_rd_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      mem_v_q   <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_rd_q  <= '0;
      wb_v_q    <= 1'b0;
      wb_wr_q   <= 1'b0;
      wb_rd_q   <= '0;
    end else if (adv) begin
      ex_v_q    <= id_valid & ~hazard;
      ex_wr_q   <= id_regwrite;
      ex_ld_q   <= id_is_load;
      ex_use1_q <= id_use1;
      ex_use2_q <= id_use2;
      ex_rd_q   <= id_rd;
      ex_rs1_q  <= id_rs1;
      ex_rs2_q  <= id_rs2;
      mem_v_q   <= ex_v_q;
      mem_wr_q  <= ex_wr_q;
      mem_ld_q  <= ex_ld_q;
      mem_rd_q  <= ex_rd_q;
      wb_v_q    <= mem_v_q;
      wb_wr_q   <= mem_wr_q;
      wb_rd_q   <= mem_rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (hazard & ~mem_busy & (stall_cnt_q != CntMax)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

  // A load result is not available at the end of EX, so it must never be bypassed from MEM.
  load_never_bypassed_from_mem: assert property (@(posedge clk) disable iff (rst)
    !(mem_ld_q && ((fwd_a == 2'b10) || (fwd_b == 2'b10))));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: default instance plus a CNT_W=2 instance
// driven by the same stimulus to observe counter saturation.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr, ld, br, tk, busy, clr;
  } stim_t;

  typedef struct {
    string       name;
    logic [3:0]  ctl;   // {stall_fd, bubble_ex, freeze, flush_fd}
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  localparam logic [3:0] Z   = 4'b0000;
  localparam logic [3:0] STB = 4'b1100;
  localparam logic [3:0] FRZ = 4'b1010;
  localparam logic [3:0] FL  = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0, id_regwrite = 1'b0;
  logic id_is_load = 1'b0, id_is_branch = 1'b0, br_taken = 1'b0;
  logic mem_busy = 1'b0, cnt_clr = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic stall_fd, bubble_ex, freeze, flush_fd;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic s_stall_fd, s_bubble_ex, s_freeze, s_flush_fd;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [1:0] s_stall_cnt;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event chk_now;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .br_taken(br_taken),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .stall_fd(stall_fd), .bubble_ex(bubble_ex),
    .freeze(freeze), .flush_fd(flush_fd), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .br_taken(br_taken),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .stall_fd(s_stall_fd), .bubble_ex(s_bubble_ex),
    .freeze(s_freeze), .flush_fd(s_flush_fd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt)
  );

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t alu(input int rd, input int rs1, input int rs2);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.wr = 1'b1; s.rd = 5'(rd);
    s.rs1 = 5'(rs1); s.u1 = 1'b1; s.rs2 = 5'(rs2); s.u2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t alui(input int rd, input int rs1);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.wr = 1'b1; s.rd = 5'(rd); s.rs1 = 5'(rs1); s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t ldi(input int rd, input int rs1);
    stim_t s;
    s = alui(rd, rs1);
    s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t br(input int rs1, input int rs2, input logic tk);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.br = 1'b1; s.tk = tk;
    s.rs1 = 5'(rs1); s.u1 = 1'b1; s.rs2 = 5'(rs2); s.u2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t with_busy(input stim_t s);
    stim_t r;
    r = s;
    r.busy = 1'b1;
    return r;
  endfunction

  function automatic stim_t with_clr(input stim_t s);
    stim_t r;
    r = s;
    r.clr = 1'b1;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_rs1 = s.rs1; id_use1 = s.u1; id_rs2 = s.rs2; id_use2 = s.u2;
    id_rd = s.rd; id_regwrite = s.wr; id_is_load = s.ld; id_is_branch = s.br;
    br_taken = s.tk; mem_busy = s.busy; cnt_clr = s.clr;
  endtask

  task automatic push(input string nm, input logic [3:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input int cnt, input int scnt);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.cnt = 16'(cnt); e.scnt = 2'(scnt);
    q.push_back(e);
  endtask

  task automatic vec(input string nm, input stim_t s, input logic [3:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb, input int cnt, input int scnt);
    @(posedge clk);
    #1;
    drive(s);
    push(nm, ctl, fa, fb, cnt, scnt);
  endtask

  // Monitor: compares on every negedge, plus on demand for the asynchronous-reset check.
  initial begin
    exp_t e;
    logic [3:0] g_ctl, s_ctl;
    forever begin
      @(negedge clk or chk_now);
      if (q.size() > 0) begin
        e = q.pop_front();
        g_ctl = {stall_fd, bubble_ex, freeze, flush_fd};
        s_ctl = {s_stall_fd, s_bubble_ex, s_freeze, s_flush_fd};
        n_vec++;
        if ({g_ctl, fwd_a, fwd_b, stall_cnt} !== {e.ctl, e.fa, e.fb, e.cnt} ||
            {s_ctl, s_fwd_a, s_fwd_b, s_stall_cnt} !== {e.ctl, e.fa, e.fb, e.scnt}) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b cnt=%0d sat_ctl=%b sat_fa=%b sat_fb=%b sat_cnt=%0d; required ctl=%b fa=%b fb=%b cnt=%0d sat_cnt=%0d",
                   e.name, g_ctl, fwd_a, fwd_b, stall_cnt, s_ctl, s_fwd_a, s_fwd_b,
                   s_stall_cnt, e.ctl, e.fa, e.fb, e.cnt, e.scnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(nop());
    vec("reset_state", nop(), Z, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // ALU result forwarded from EX/MEM without stalling
    vec("fwd_add",        alu(5, 1, 2), Z, 2'b00, 2'b00, 0, 0);
    vec("fwd_sub_nostall", alu(6, 5, 1), Z, 2'b00, 2'b00, 0, 0);
    vec("fwd_sub_in_ex",  nop(),        Z, 2'b10, 2'b00, 0, 0);
    vec("fwd_drain",      nop(),        Z, 2'b00, 2'b00, 0, 0);

    // Load-use: one bubble, then operands from WB
    vec("lu_load",        ldi(7, 1),    Z,   2'b00, 2'b00, 0, 0);
    vec("lu_stall",       alu(8, 7, 7), STB, 2'b00, 2'b00, 0, 0);
    vec("lu_release",     alu(8, 7, 7), Z,   2'b00, 2'b00, 1, 1);
    vec("lu_fwd_wb",      nop(),        Z,   2'b01, 2'b01, 1, 1);
    vec("lu_drain",       nop(),        Z,   2'b00, 2'b00, 1, 1);

    // Branch resolved in ID waits for an ALU producer in EX, then flushes once
    vec("br_addi",        alui(3, 1),      Z,   2'b00, 2'b00, 1, 1);
    vec("br_stall",       br(3, 4, 1'b1),  STB, 2'b00, 2'b00, 1, 1);
    vec("br_flush",       br(3, 4, 1'b1),  FL,  2'b00, 2'b00, 2, 2);
    vec("br_flush_once",  nop(),           Z,   2'b01, 2'b00, 2, 2);
    vec("br_drain",       nop(),           Z,   2'b00, 2'b00, 2, 2);

    // Memory busy during a load-use pair: freeze without bubble or count
    vec("busy_load",      ldi(9, 1),                  Z,   2'b00, 2'b00, 2, 2);
    vec("busy_1",         with_busy(alu(10, 9, 2)),   FRZ, 2'b00, 2'b00, 2, 2);
    vec("busy_2",         with_busy(alu(10, 9, 2)),   FRZ, 2'b00, 2'b00, 2, 2);
    vec("busy_3",         with_busy(alu(10, 9, 2)),   FRZ, 2'b00, 2'b00, 2, 2);
    vec("busy_drop",      alu(10, 9, 2),              STB, 2'b00, 2'b00, 2, 2);
    vec("busy_release",   alu(10, 9, 2),              Z,   2'b00, 2'b00, 3, 3);
    vec("busy_fwd_wb",    nop(),                      Z,   2'b01, 2'b00, 3, 3);

    // x0 is never a hazard or forwarding source, even from a load
    vec("x0_writer",      ldi(0, 1),     Z, 2'b00, 2'b00, 3, 3);
    vec("x0_no_hazard",   alu(11, 0, 0), Z, 2'b00, 2'b00, 3, 3);
    vec("x0_no_fwd",      nop(),         Z, 2'b00, 2'b00, 3, 3);
    vec("x0_drain",       nop(),         Z, 2'b00, 2'b00, 3, 3);

    // Further load-use stalls: wide counter keeps going, 2-bit counter sticks at 3
    for (int k = 0; k < 3; k++) begin
      vec("sat_load",     ldi(12, 1),     Z,   2'b00, 2'b00, 3 + k, 3);
      vec("sat_stall",    alui(13, 12),   STB, 2'b00, 2'b00, 3 + k, 3);
      vec("sat_release",  alui(13, 12),   Z,   2'b00, 2'b00, 4 + k, 3);
      vec("sat_fwd_wb",   nop(),          Z,   2'b01, 2'b00, 4 + k, 3);
    end

    // Reset during a stall, with the consumer still presented in ID
    vec("rst_load",       ldi(14, 1),   Z,   2'b00, 2'b00, 6, 3);
    vec("rst_pre_stall",  alui(15, 14), STB, 2'b00, 2'b00, 6, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    push("rst_async", Z, 2'b00, 2'b00, 0, 0);
    -> chk_now;
    vec("rst_held",       nop(),        Z, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    vec("rst_no_stale_haz", alui(15, 14), Z, 2'b00, 2'b00, 0, 0);
    vec("rst_no_stale_fwd", nop(),        Z, 2'b00, 2'b00, 0, 0);

    // Counter clear, including clear winning over a same-cycle increment
    vec("clr_load",       ldi(12, 1),             Z,   2'b00, 2'b00, 0, 0);
    vec("clr_stall",      alui(13, 12),           STB, 2'b00, 2'b00, 0, 0);
    vec("clr_release",    alui(13, 12),           Z,   2'b00, 2'b00, 1, 1);
    vec("clr_fwd",        nop(),                  Z,   2'b01, 2'b00, 1, 1);
    vec("clr_apply",      with_clr(nop()),        Z,   2'b00, 2'b00, 1, 1);
    vec("clr_done",       nop(),                  Z,   2'b00, 2'b00, 0, 0);
    vec("clr_load2",      ldi(12, 1),             Z,   2'b00, 2'b00, 0, 0);
    vec("clr_vs_inc",     with_clr(alui(13, 12)), STB, 2'b00, 2'b00, 0, 0);
    vec("clr_priority",   alui(13, 12),           Z,   2'b00, 2'b00, 0, 0);
    vec("clr_fwd2",       nop(),                  Z,   2'b01, 2'b00, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked vectors, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
